// File: rtl/alu_issue.sv
// alu_issue: decode/issue/writeback sequencer for RV32I OP and OP-IMM.
// The unit accepts one instruction, presents its operands to an external
// combinational ALU, captures the result, and writes it back to rd.
// Throughput is one instruction every three cycles (IDLE -> EXEC -> WB).
module alu_issue #(
  parameter int unsigned NREGS = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_instr,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  output logic [3:0]  o_alu_op,
  input  logic [31:0] i_alu_res,
  output logic        o_done,
  output logic        o_illegal,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  input  logic [4:0]  i_dbg_addr,
  output logic [31:0] o_dbg_data
);

  // ALU opcode encoding shared with the external ALU
  localparam logic [3:0] ALU_OP_ADD  = 4'd0;
  localparam logic [3:0] ALU_OP_SUB  = 4'd1;
  localparam logic [3:0] ALU_OP_SLL  = 4'd2;
  localparam logic [3:0] ALU_OP_SLT  = 4'd3;
  localparam logic [3:0] ALU_OP_SLTU = 4'd4;
  localparam logic [3:0] ALU_OP_XOR  = 4'd5;
  localparam logic [3:0] ALU_OP_SRL  = 4'd6;
  localparam logic [3:0] ALU_OP_SRA  = 4'd7;
  localparam logic [3:0] ALU_OP_OR   = 4'd8;
  localparam logic [3:0] ALU_OP_AND  = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam int unsigned AW = $clog2(NREGS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Architectural register file; entry 0 exists but is never written
  logic [31:0] rf [NREGS];

  // Operands and control latched at accept
  logic [31:0] a_q, b_q;
  logic [3:0]  op_q;
  logic [4:0]  rd_q;
  logic        ill_q;

  // Result register and retired-instruction tag
  logic [31:0] wb_data_q;
  logic [4:0]  wb_rd_q;

  // Instruction fields
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;

  assign opcode = i_instr[6:0];
  assign rd     = i_instr[11:7];
  assign funct3 = i_instr[14:12];
  assign rs1    = i_instr[19:15];
  assign rs2    = i_instr[24:20];
  assign funct7 = i_instr[31:25];

  function automatic logic idx_ok(input logic [4:0] idx);
    return 32'(idx) < NREGS;
  endfunction

  // Register read ports: x0 and out-of-range indices read as zero
  logic [31:0] rs1_val, rs2_val;

  assign rs1_val    = (rs1 != '0 && idx_ok(rs1)) ? rf[rs1[AW-1:0]] : '0;
  assign rs2_val    = (rs2 != '0 && idx_ok(rs2)) ? rf[rs2[AW-1:0]] : '0;
  assign o_dbg_data = (i_dbg_addr != '0 && idx_ok(i_dbg_addr)) ? rf[i_dbg_addr[AW-1:0]] : '0;

  // Decode of the presented instruction into ALU controls and legality
  logic [31:0] dec_a, dec_b;
  logic [3:0]  dec_op;
  logic        dec_ill;
  logic        is_op, is_imm, is_shift, f7_alt;

  // Combinational decode: operands, ALU opcode and illegal flag
  always_comb begin
    dec_a    = rs1_val;
    dec_b    = '0;
    dec_op   = ALU_OP_ADD;
    dec_ill  = 1'b0;
    is_op    = (opcode == OPC_OP);
    is_imm   = (opcode == OPC_OP_IMM);
    is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    f7_alt   = (funct7 == F7_ALT);

    unique case (funct3)
      3'b000:  dec_op = (is_op && f7_alt) ? ALU_OP_SUB : ALU_OP_ADD;
      3'b001:  dec_op = ALU_OP_SLL;
      3'b010:  dec_op = ALU_OP_SLT;
      3'b011:  dec_op = ALU_OP_SLTU;
      3'b100:  dec_op = ALU_OP_XOR;
      3'b101:  dec_op = f7_alt ? ALU_OP_SRA : ALU_OP_SRL;
      3'b110:  dec_op = ALU_OP_OR;
      default: dec_op = ALU_OP_AND;
    endcase

    if (is_op) begin
      dec_b = rs2_val;
      if (!(funct7 == F7_BASE ||
            (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101))))
        dec_ill = 1'b1;
      if (!idx_ok(rs2))
        dec_ill = 1'b1;
    end else if (is_imm) begin
      if (is_shift) begin
        dec_b = {27'b0, i_instr[24:20]};
        if (!(funct7 == F7_BASE || (f7_alt && funct3 == 3'b101)))
          dec_ill = 1'b1;
      end else begin
        dec_b = {{20{i_instr[31]}}, i_instr[31:20]};
      end
    end else begin
      dec_ill = 1'b1;
    end

    if (!idx_ok(rs1) || !idx_ok(rd))
      dec_ill = 1'b1;
  end

  logic accept;

  // Ready is suppressed during reset so no instruction is taken while it is held
  assign o_ready = (state == S_IDLE) && !i_rst;
  assign accept  = i_valid && o_ready;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: only IDLE waits on a handshake
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Issue latch at accept, result capture at the end of EXEC
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= ALU_OP_ADD;
      rd_q      <= '0;
      ill_q     <= 1'b0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
    end else begin
      if (accept) begin
        a_q   <= dec_a;
        b_q   <= dec_b;
        op_q  <= dec_op;
        rd_q  <= rd;
        ill_q <= dec_ill;
      end
      if (state == S_EXEC) begin
        wb_data_q <= i_alu_res;
        wb_rd_q   <= rd_q;
      end
    end
  end

  // Register file writeback at the end of WB; x0 and illegal results are dropped
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rf <= '{default: '0};
    end else if (state == S_WB && !ill_q && wb_rd_q != '0) begin
      rf[wb_rd_q[AW-1:0]] <= wb_data_q;
    end
  end

  assign o_alu_a   = a_q;
  assign o_alu_b   = b_q;
  assign o_alu_op  = op_q;
  assign o_done    = (state == S_WB);
  assign o_illegal = (state == S_WB) && ill_q;
  assign o_wb_rd   = wb_rd_q;
  assign o_wb_data = wb_data_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: models the external ALU, issues directed
// instructions with hand-computed results, and checks retirements from
// a scoreboard queue in an independent monitor process.
module tb_alu_issue;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_instr;
  logic [31:0] o_alu_a, o_alu_b;
  logic [3:0]  o_alu_op;
  logic [31:0] alu_res;
  logic        o_done, o_illegal;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ill;
    logic        chk_data;
    int unsigned cyc;
  } exp_t;

  exp_t sb[$];

  alu_issue #(.NREGS(32)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_instr    (i_instr),
    .o_alu_a    (o_alu_a),
    .o_alu_b    (o_alu_b),
    .o_alu_op   (o_alu_op),
    .i_alu_res  (alu_res),
    .o_done     (o_done),
    .o_illegal  (o_illegal),
    .o_wb_rd    (o_wb_rd),
    .o_wb_data  (o_wb_data),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External combinational ALU
  always_comb begin
    alu_res = '0;
    case (o_alu_op)
      OP_ADD:  alu_res = o_alu_a + o_alu_b;
      OP_SUB:  alu_res = o_alu_a - o_alu_b;
      OP_SLL:  alu_res = o_alu_a << o_alu_b[4:0];
      OP_SLT:  alu_res = {31'b0, $signed(o_alu_a) < $signed(o_alu_b)};
      OP_SLTU: alu_res = {31'b0, o_alu_a < o_alu_b};
      OP_XOR:  alu_res = o_alu_a ^ o_alu_b;
      OP_SRL:  alu_res = o_alu_a >> o_alu_b[4:0];
      OP_SRA:  alu_res = $signed(o_alu_a) >>> o_alu_b[4:0];
      OP_OR:   alu_res = o_alu_a | o_alu_b;
      OP_AND:  alu_res = o_alu_a & o_alu_b;
      default: alu_res = '0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every retirement must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && o_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(o_wb_rd), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("wb_rd", 32'(o_wb_rd), 32'(e.rd));
        chk("wb_illegal", 32'(o_illegal), 32'(e.ill));
        chk("done_latency", cyc, e.cyc);
        chk("ready_in_wb", 32'(o_ready), 32'd0);
        if (e.chk_data) chk("wb_data", o_wb_data, e.data);
      end
    end
  end

  // Present an instruction and push its expectation on the accepting edge
  task automatic issue(input logic [31:0] ins, input logic [4:0] rd,
                       input logic [31:0] data, input logic ill,
                       output int unsigned acc);
    int unsigned n;
    exp_t e;
    i_valid = 1'b1;
    i_instr = ins;
    n = 0;
    acc = 0;
    while (!o_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!o_ready) begin
      chk("accept_timeout", 32'(o_ready), 32'd1);
    end else begin
      acc        = cyc;
      e.rd       = rd;
      e.data     = data;
      e.ill      = ill;
      e.chk_data = !ill;
      e.cyc      = cyc + 2;
      sb.push_back(e);
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    int unsigned n;
    i_valid = 1'b0;
    n = 0;
    while (!o_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", 32'(o_ready), 32'd1);
  endtask

  task automatic chk_reg(input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk($sformatf("dbg_x%0d", a), dbg_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned a0, a1, a2;
    rst = 1'b1;
    i_valid = 1'b0;
    i_instr = '0;
    dbg_addr = '0;
    #2;
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_alu_op", 32'(o_alu_op), 32'(OP_ADD));
    chk("rst_wb_data", o_wb_data, 32'd0);
    chk_reg(5'd1, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(o_ready), 32'd1);

    // ADDI x1,x0,5
    issue(32'h00500093, 5'd1, 32'd5, 1'b0, a0);
    wait_idle();
    chk_reg(5'd1, 32'd5);

    // ADDI x2,x0,3 ; ADD x3,x1,x2 ; SUB x4,x1,x2
    issue(32'h00300113, 5'd2, 32'd3, 1'b0, a0);
    issue(32'h002081B3, 5'd3, 32'd8, 1'b0, a0);
    issue(32'h40208233, 5'd4, 32'd2, 1'b0, a0);
    chk("sub_op_exec", 32'(o_alu_op), 32'(OP_SUB));
    chk("sub_a_exec", o_alu_a, 32'd5);
    chk("sub_b_exec", o_alu_b, 32'd3);
    wait_idle();
    chk_reg(5'd3, 32'd8);
    chk_reg(5'd4, 32'd2);

    // ADDI x6,x0,-1 ; SRLI x7,x6,4 ; SRAI x5,x6,4
    issue(32'hFFF00313, 5'd6, 32'hFFFF_FFFF, 1'b0, a0);
    issue(32'h00435393, 5'd7, 32'h0FFF_FFFF, 1'b0, a0);
    issue(32'h40435293, 5'd5, 32'hFFFF_FFFF, 1'b0, a0);
    wait_idle();
    chk_reg(5'd7, 32'h0FFF_FFFF);
    chk_reg(5'd5, 32'hFFFF_FFFF);

    // SLTIU x8,x0,-1 ; SLT x9,x6,x1 ; SLTU x10,x6,x1 ; SLLI x11,x1,3
    issue(32'hFFF03413, 5'd8, 32'd1, 1'b0, a0);
    issue(32'h001324B3, 5'd9, 32'd1, 1'b0, a0);
    issue(32'h00133533, 5'd10, 32'd0, 1'b0, a0);
    issue(32'h00309593, 5'd11, 32'h28, 1'b0, a0);
    wait_idle();
    chk_reg(5'd8, 32'd1);
    chk_reg(5'd11, 32'h28);

    // ADDI x0,x0,7: result shown, write dropped
    issue(32'h00700013, 5'd0, 32'd7, 1'b0, a0);
    wait_idle();
    chk_reg(5'd0, 32'd0);

    // Illegal: OP funct7=0000001, SLLI funct7=0100000, unknown opcode
    issue(32'h022081B3, 5'd3, 32'd0, 1'b1, a0);
    issue(32'h40309593, 5'd11, 32'd0, 1'b1, a0);
    issue(32'h0000007F, 5'd0, 32'd0, 1'b1, a0);
    wait_idle();
    chk_reg(5'd3, 32'd8);
    chk_reg(5'd11, 32'h28);

    // i_valid held high: dependent chain x13 = 1, 2, 3
    issue(32'h00100693, 5'd13, 32'd1, 1'b0, a0);
    issue(32'h00168693, 5'd13, 32'd2, 1'b0, a1);
    chk("ready_exec", 32'(o_ready), 32'd0);
    issue(32'h00168693, 5'd13, 32'd3, 1'b0, a2);
    chk("accept_gap_1", a1 - a0, 32'd3);
    chk("accept_gap_2", a2 - a1, 32'd3);
    wait_idle();
    chk_reg(5'd13, 32'd3);

    // Reset during EXEC of ADDI x1,x0,9: instruction discarded
    i_valid = 1'b1;
    i_instr = 32'h00900093;
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("rst_test_exec_b", o_alu_b, 32'd9);
    rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(o_ready), 32'd0);
    chk("midrst_done", 32'(o_done), 32'd0);
    chk("midrst_alu_b", o_alu_b, 32'd0);
    chk("midrst_wb_data", o_wb_data, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_midrst", 32'(o_ready), 32'd1);
    chk_reg(5'd1, 32'd0);
    chk_reg(5'd13, 32'd0);
    repeat (4) @(posedge clk);
    #1;

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
